// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter and its passive monitor.
package counter_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_t;

  // Modular +/-1 step the counter is contracted to take each cycle.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c, input logic up);
    return up ? c + 1'b1 : c - 1'b1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst)                          r_count <= '0;
    else if (i_inc && (r_count != '1))  r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/counter_monitor.sv
// Passive checker for the up/down counter: flags non +/-1 steps, reports wraps,
// tallies errors and re-synchronises after RESYNC consecutive good steps.
module counter_monitor
  import counter_pkg::*;
#(
  parameter int WIDTH     = CNT_W,
  parameter int ERR_W     = 8,
  parameter int RESYNC    = 4,
  parameter int CHECK_RST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] cnt,
  output logic             err,
  output logic             fault,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);

  localparam int GR_W = (RESYNC < 2) ? 1 : $clog2(RESYNC + 1);

  mon_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_prev_cnt;
  logic             r_prev_mode;
  logic [GR_W-1:0]  r_good_run, w_good_nxt;
  logic             r_err, r_wrap_up, r_wrap_down;
  logic             w_err_nxt, w_wu_nxt, w_wd_nxt;
  logic [WIDTH-1:0] w_exp;
  logic             w_match;

  generate
    if (WIDTH == CNT_W) begin : g_pkg_step
      assign w_exp = cnt_next(r_prev_cnt, r_prev_mode);
    end else begin : g_local_step
      assign w_exp = r_prev_mode ? r_prev_cnt + 1'b1 : r_prev_cnt - 1'b1;
    end
  endgenerate

  assign w_match = (cnt == w_exp);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_run;
    w_err_nxt   = 1'b0;
    w_wu_nxt    = 1'b0;
    w_wd_nxt    = 1'b0;
    case (r_state)
      TRACK: begin
        if (!w_match) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = FAULT;
          w_good_nxt  = '0;
        end else begin
          w_wu_nxt = r_prev_mode && (r_prev_cnt == '1);
          w_wd_nxt = !r_prev_mode && (r_prev_cnt == '0);
        end
      end
      FAULT: begin
        // Wraps are not reported here even on a good step.
        if (!w_match) begin
          w_err_nxt  = 1'b1;
          w_good_nxt = '0;
        end else if (r_good_run == GR_W'(RESYNC - 1)) begin
          w_state_nxt = TRACK;
          w_good_nxt  = '0;
        end else begin
          w_good_nxt = r_good_run + 1'b1;
        end
      end
      default: begin
        // First sample after reset; encoding 3 lands here as well.
        if ((CHECK_RST != 0) && (cnt != '0)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = FAULT;
          w_good_nxt  = '0;
        end else begin
          w_state_nxt = TRACK;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SYNC;
      r_prev_cnt  <= '0;
      r_prev_mode <= 1'b0;
      r_good_run  <= '0;
      r_err       <= 1'b0;
      r_wrap_up   <= 1'b0;
      r_wrap_down <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev_cnt  <= cnt;
      r_prev_mode <= mode;
      r_good_run  <= w_good_nxt;
      r_err       <= w_err_nxt;
      r_wrap_up   <= w_wu_nxt;
      r_wrap_down <= w_wd_nxt;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_tally (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_err_nxt),
    .o_count (err_cnt)
  );

  assign err       = r_err;
  assign fault     = (r_state == FAULT);
  assign wrap_up   = r_wrap_up;
  assign wrap_down = r_wrap_down;
  assign state     = r_state;

endmodule

// File: tb/tb_counter_monitor.sv
// Self-checking bench: directed plan segments plus random streams, checked every
// cycle against a behavioural model of the counter contract.
module tb_counter_monitor;

  logic       clk, rst, mode;
  logic [9:0] cnt;
  logic       err, fault, wrap_up, wrap_down;
  logic [7:0] err_cnt;
  logic [1:0] state;

  int checks = 0;
  int fails  = 0;

  counter_monitor #(.WIDTH(10), .ERR_W(8), .RESYNC(4), .CHECK_RST(1)) dut (
    .clk(clk), .rst(rst), .mode(mode), .cnt(cnt),
    .err(err), .fault(fault), .wrap_up(wrap_up), .wrap_down(wrap_down),
    .err_cnt(err_cnt), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = awaiting first sample, 1 = tracking, 2 = faulted.
  int armed = 0;
  int m_phase, m_prev, m_pmode, m_good;
  int e_err, e_wu, e_wd, e_cnt;

  function automatic int model_exp();
    return (m_prev + (m_pmode != 0 ? 1 : 1023)) % 1024;
  endfunction

  always @(posedge clk) begin
    int ok;
    if (rst) begin
      armed = 1; m_phase = 0; m_prev = 0; m_pmode = 0; m_good = 0;
      e_err = 0; e_wu = 0; e_wd = 0; e_cnt = 0;
    end else if (armed != 0) begin
      ok = (int'(cnt) == model_exp()) ? 1 : 0;
      e_err = 0; e_wu = 0; e_wd = 0;
      if (m_phase == 0) begin
        if (cnt != 0) begin e_err = 1; m_phase = 2; m_good = 0; end
        else m_phase = 1;
      end else if (ok == 0) begin
        e_err = 1; m_phase = 2; m_good = 0;
      end else if (m_phase == 1) begin
        e_wu = (mode === 1'b1 || m_pmode != 0) && m_pmode != 0 && cnt == 0 ? 1 : 0;
        e_wd = (m_pmode == 0 && cnt == 1023) ? 1 : 0;
      end else begin
        m_good++;
        if (m_good == 4) begin m_phase = 1; m_good = 0; end
      end
      if (e_err != 0 && e_cnt < 255) e_cnt++;
      m_prev = int'(cnt); m_pmode = int'(mode);
    end
  end

  int n_err = 0, n_wu = 0, n_wd = 0;

  always @(negedge clk) begin
    if (armed != 0) begin
      chk("err",       err,       e_err);
      chk("wrap_up",   wrap_up,   e_wu);
      chk("wrap_down", wrap_down, e_wd);
      chk("fault",     fault,     (m_phase == 2) ? 1 : 0);
      chk("err_cnt",   err_cnt,   e_cnt);
      chk("state",     state,     m_phase);
      if (err === 1'b1 && (wrap_up === 1'b1 || wrap_down === 1'b1)) chk("err_wrap_excl", 1, 0);
      if (err === 1'b1)       n_err++;
      if (wrap_up === 1'b1)   n_wu++;
      if (wrap_down === 1'b1) n_wd++;
    end
  end

  task automatic step(input logic r, input logic m, input int c);
    @(negedge clk);
    rst = r; mode = m; cnt = c[9:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e0, u0, d0, v, gl;
    rst = 1'b1; mode = 1'b0; cnt = '0;

    step(1, 1, 0); step(1, 1, 0);
    chk("rst_state", state, 0);   chk("rst_err", err, 0);
    chk("rst_fault", fault, 0);   chk("rst_wu", wrap_up, 0);
    chk("rst_wd", wrap_down, 0);  chk("rst_errcnt", err_cnt, 0);

    // Clean up-count from zero.
    e0 = n_err;
    for (int i = 0; i <= 10; i++) begin
      step(0, 1, i);
      if (i == 0) chk("first_sample_track", state, 1);
    end
    chk("clean_errcnt", err_cnt, 0);
    step(1, 0, 0);
    chk("clean_no_err", n_err - e0, 0);

    // Down wrap, turn round, up wrap, down wrap again.
    e0 = n_err; u0 = n_wu; d0 = n_wd;
    step(0, 0, 0);
    step(0, 0, 1023); chk("wd_0_to_max", wrap_down, 1);
    step(0, 0, 1022);
    step(0, 1, 1021);
    step(0, 1, 1022);
    step(0, 1, 1023); chk("no_wu_early", wrap_up, 0);
    step(0, 0, 0);    chk("wu_max_to_0", wrap_up, 1); chk("no_wd_on_up", wrap_down, 0);
    step(0, 0, 1023); chk("wd_again", wrap_down, 1);
    step(1, 0, 0);
    chk("wu_total", n_wu - u0, 1); chk("wd_total", n_wd - d0, 2);
    chk("wrap_no_err", n_err - e0, 0);

    // Direction flip uses previous-cycle mode.
    e0 = n_err;
    for (int i = 0; i <= 4; i++) step(0, 1, i);
    step(0, 1, 5); step(0, 1, 6); step(0, 0, 7); step(0, 1, 6); step(0, 1, 7);
    chk("flip_track", state, 1);
    step(1, 0, 0);
    chk("flip_no_err", n_err - e0, 0);

    // Skip then resync after four good steps.
    for (int i = 0; i <= 4; i++) step(0, 1, i);
    step(0, 1, 6);
    chk("skip_err", err, 1); chk("skip_fault", fault, 1);
    chk("skip_errcnt", err_cnt, 1); chk("skip_state", state, 2);
    step(0, 1, 7);  chk("rs1_err", err, 0); chk("rs1_fault", fault, 1);
    step(0, 1, 8);  chk("rs2_fault", fault, 1);
    step(0, 1, 9);  chk("rs3_fault", fault, 1);
    step(0, 1, 10); chk("rs4_fault", fault, 0); chk("rs4_state", state, 1);

    // Bad reset value, then saturate the tally with mismatches.
    step(1, 1, 0);
    step(0, 1, 7);
    chk("badrst_err", err, 1); chk("badrst_fault", fault, 1);
    chk("badrst_state", state, 2); chk("badrst_errcnt", err_cnt, 1);
    for (int i = 0; i < 300; i++) begin
      v = $urandom_range(0, 1023);
      if (v == model_exp()) v = v ^ 1;
      step(0, 1'($urandom_range(0, 1)), v);
    end
    chk("sat_errcnt", err_cnt, 255); chk("sat_fault", fault, 1);
    step(1, 0, 0);
    chk("midrst_state", state, 0); chk("midrst_err", err, 0);
    chk("midrst_fault", fault, 0); chk("midrst_errcnt", err_cnt, 0);
    chk("midrst_wu", wrap_up, 0);  chk("midrst_wd", wrap_down, 0);

    // Mostly-legal random walk with glitches and occasional resets.
    for (int i = 0; i < 800; i++) begin
      gl = $urandom_range(0, 11);
      if ($urandom_range(0, 99) == 0) step(1, 0, 0);
      else begin
        if (m_phase == 0) v = (gl == 0) ? $urandom_range(1, 1023) : 0;
        else if (gl == 0) v = $urandom_range(0, 1023);
        else v = model_exp();
        step(0, 1'($urandom_range(0, 1)), v);
      end
    end
    step(1, 0, 0);
    chk("end_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/counter_monitor.md
# counter_monitor

Passive observer for the 10-bit up/down counter, the consumer end of the counter's `cnt`/`mode` interface. It samples the counter's mode input and count output every cycle and keeps a shadow expectation of the next value. It flags any step that is not exactly ±1 (modulo 2^WIDTH), reports wrap-around events and keeps a saturating error tally. It sits beside the counter in the `counter_8` testbench and FPGA debug builds, and drives nothing back into the counter.

## Interface
- `WIDTH`, 10, counter width in bits.
- `ERR_W`, 8, width of the saturating error tally.
- `RESYNC`, 4, consecutive correct steps required to leave FAULT (≥1).
- `CHECK_RST`, 1, when 1 the first post-reset sample must equal 0.
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-high; same signal that resets the counter.
- `mode` input 1: counter direction as driven to the counter; 1 = up, 0 = down.
- `cnt` input WIDTH: counter output.
- `err` output 1: one-cycle pulse, step mismatch detected.
- `fault` output 1: level, high while in FAULT.
- `wrap_up` output 1: one-cycle pulse, correct step max→0 in up mode.
- `wrap_down` output 1: one-cycle pulse, correct step 0→max in down mode.
- `err_cnt` output ERR_W: saturating count of `err` pulses.
- `state` output 2: FSM state encoding, for debug.

## Operation
- Counter contract: at posedge k with `rst`=0, `cnt(k+1) = cnt(k) + 1` if `mode(k)`, else `cnt(k) − 1`, both mod 2^WIDTH. With `rst`=1, `cnt(k+1)` = 0.
- Registers: `prev_cnt`, `prev_mode`, `good_run` (counts to RESYNC), FSM.
- States: SYNC=0, TRACK=1, FAULT=2 (3 unused; treated as SYNC).
- SYNC: entered on reset. On the first edge with `rst`=0, capture `cnt`/`mode` and go to TRACK. If CHECK_RST=1 and `cnt`≠0, pulse `err`, go to FAULT instead.
- TRACK: `exp` = `prev_cnt` ± 1 per `prev_mode`. A mismatch pulses `err` and moves to FAULT with `good_run`=0. A match returns to TRACK and raises the wrap pulse when `prev_cnt`=max in up mode or `prev_cnt`=0 in down mode.
- FAULT: same comparison every cycle. A match increments `good_run`. A mismatch pulses `err` and clears `good_run`. When `good_run` reaches RESYNC, go to TRACK. Wrap pulses are suppressed in FAULT.
- `prev_cnt`/`prev_mode` always reload from the current sample, so the check self-aligns after a glitch.
- `err_cnt` increments on each `err` and holds at 2^ERR_W−1.
- `rst` high at any time, including mid-FAULT: all state returns to reset values on that edge. The sample taken on that edge is ignored.
- Mode change between cycles is legal. Expectation always uses the mode from the previous cycle.

## Timing
- Reset values: `err`=0, `fault`=0, `wrap_up`=0, `wrap_down`=0, `err_cnt`=0, `state`=SYNC.
- All outputs are registered. The response to the sample at edge k appears after edge k, i.e. valid during cycle k.
- `err` and the wrap pulses are exactly one cycle wide. Back-to-back mismatches give a continuous `err` high, one increment per cycle.
- `fault` rises in the same cycle as the `err` that caused it. It falls in the cycle after the RESYNC-th consecutive match.
- `err` and a wrap pulse are never high together.

## Structure
- Shared package `counter_pkg`:
  - state enum `mon_state_t` {SYNC, TRACK, FAULT};
  - `CNT_W` = 10, used by both counter and monitor;
  - function `cnt_next(cnt, mode)` returning the modular ±1 value.
- One sub-module, `sat_counter` (ERR_W, increment enable, synchronous reset), for `err_cnt`. Everything else stays in `counter_monitor`.

## Test plan
- Reset then clean count: `rst` for 2 cycles, then `mode`=1 with `cnt` 0,1,2,…,10 → state TRACK after the first sample; `err` never high; `err_cnt`=0.
- Up wrap and down wrap: `cnt` 1022,1023,0 with `mode`=1 → single `wrap_up` on the 1023→0 step. Then `mode`=0 with `cnt` 0,1023 → single `wrap_down`.
- Direction flip: `mode` 1,1,0,1 with `cnt` 5,6,7,6,7 → no `err`; expectation follows the previous-cycle mode.
- Injected skip and resync (RESYNC=4): `cnt` 3,4,6 (up) → `err` pulse, `fault`=1, `err_cnt`=1. Then 7,8,9,10 → `fault` falls after 10, state TRACK.
- Bad reset value and saturation: CHECK_RST=1 with first post-reset `cnt`=7 → `err`, FAULT. Then 300 random values → `err_cnt` holds at 255. Asserting `rst` mid-FAULT → all outputs 0, state SYNC next cycle.
